// File: rtl/puf_key_receiver_if.sv
// puf_key_receiver_if: PUF response input and AES key valid/ready output bundle
interface puf_key_receiver_if #(parameter int KEY_W = 128);
  logic [KEY_W-1:0] puf_key;
  logic             puf_enable;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             key_ready;
  modport master (input puf_key, puf_enable, key_ready, output key_out, key_valid);
  modport slave (output puf_key, puf_enable, key_ready, input key_out, key_valid);
endinterface

// File: rtl/puf_key_receiver.sv
// puf_key_receiver: samples a PUF response N times, majority-votes a key and hands it to AES
module puf_key_receiver #(
  parameter int KEY_W     = 128,
  parameter int N_SAMPLES = 5,
  parameter int GAP       = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  puf_key_receiver_if.master bus,
  output logic               busy,
  output logic               error,
  output logic [7:0]         unstable_bits
);
  localparam int CW = $clog2(N_SAMPLES + 1);
  localparam int SW = $clog2(N_SAMPLES);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SAMPLE, S_GAP, S_VOTE, S_HOLD} state_t;
  state_t           st, nxt;
  logic [CW-1:0]    cnt [KEY_W];
  logic [SW-1:0]    sample_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [TW-1:0]    to_cnt;
  logic [KEY_W-1:0] key_q, vote;
  logic [31:0]      ucount;
  logic             en;
  assign en            = bus.puf_enable;
  assign bus.key_out   = key_q;
  assign bus.key_valid = st == S_HOLD;
  assign busy          = st inside {S_WAIT, S_SAMPLE, S_GAP, S_VOTE};
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= S_IDLE;
    else st <= nxt;
  // next state; losing enable while sampling aborts the run
  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:   nxt = start ? S_WAIT : S_IDLE;
      S_WAIT:   nxt = en ? S_SAMPLE : (to_cnt == TW'(TIMEOUT - 1) ? S_IDLE : S_WAIT);
      S_SAMPLE: nxt = !en ? S_IDLE : sample_cnt == SW'(N_SAMPLES - 1) ? S_VOTE : GAP == 0 ? S_SAMPLE : S_GAP;
      S_GAP:    nxt = !en ? S_IDLE : gap_cnt == GW'(GAP - 1) ? S_SAMPLE : S_GAP;
      S_VOTE:   nxt = S_HOLD;
      S_HOLD:   nxt = bus.key_ready ? S_IDLE : S_HOLD;
      default:  nxt = S_IDLE;
    endcase
  end
  // per-bit majority and count of bits whose samples disagreed
  always_comb begin
    vote   = '0;
    ucount = '0;
    for (int i = 0; i < KEY_W; i++) begin
      vote[i] = cnt[i] > CW'(N_SAMPLES / 2);
      ucount  = ucount + 32'(cnt[i] != '0 && cnt[i] != CW'(N_SAMPLES));
    end
  end
  // counters, accumulation, error flag and voted result registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sample_cnt    <= '0;
      gap_cnt       <= '0;
      to_cnt        <= '0;
      error         <= 1'b0;
      key_q         <= '0;
      unstable_bits <= '0;
      for (int i = 0; i < KEY_W; i++) cnt[i] <= '0;
    end else begin
      if (st == S_IDLE && start) begin
        sample_cnt <= '0;
        to_cnt     <= '0;
        error      <= 1'b0;
        for (int i = 0; i < KEY_W; i++) cnt[i] <= '0;
      end
      if (st == S_WAIT && !en) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_cnt == TW'(TIMEOUT - 1)) error <= 1'b1;
      end
      if ((st == S_SAMPLE || st == S_GAP) && !en) error <= 1'b1;
      if (st == S_SAMPLE && en) begin
        sample_cnt <= sample_cnt + 1'b1;
        gap_cnt    <= '0;
        for (int i = 0; i < KEY_W; i++) cnt[i] <= cnt[i] + CW'(bus.puf_key[i]);
      end
      if (st == S_GAP && en) gap_cnt <= gap_cnt + 1'b1;
      if (st == S_VOTE) begin
        key_q         <= vote;
        unstable_bits <= ucount > 32'd255 ? 8'd255 : ucount[7:0];
      end
    end
endmodule

// File: tb/tb_puf_key_receiver.sv
// tb_puf_key_receiver: directed and randomized checks of puf_key_receiver against a majority-vote model
module tb_puf_key_receiver;
  localparam int N = 5, G = 2, TO = 16;
  localparam int LAT = (N - 1) * (G + 1) + 2;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, busy, error;
  logic [7:0] unstable_bits;
  logic [127:0] smp [N];
  int compared = 0, mism = 0;
  puf_key_receiver_if #(.KEY_W(128)) bus ();
  puf_key_receiver #(.KEY_W(128), .N_SAMPLES(N), .GAP(G), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .error(error), .unstable_bits(unstable_bits)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  function automatic void model(output logic [127:0] k, output int u);
    k = '0;
    u = 0;
    for (int i = 0; i < 128; i++) begin
      int ones = 0;
      bit diff = 1'b0;
      for (int s = 0; s < N; s++) begin
        ones += int'(smp[s][i]);
        diff |= smp[s][i] != smp[0][i];
      end
      k[i] = 2 * ones > N;
      u += int'(diff);
    end
    if (u > 255) u = 255;
  endfunction
  task automatic run(input string tag, input int hold, input int drop_t);
    logic [127:0] ek;
    int eu;
    model(ek, eu);
    start = 1'b1;
    bus.puf_enable = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_err_clr"}, 128'(error), 128'(0));
    tick();
    for (int t = 0; t < LAT; t++) begin
      bus.puf_key = (t % (G + 1) == 0) ? smp[t / (G + 1)] : rnd128();
      chk({tag, "_busy"}, 128'(busy), 128'(1));
      chk({tag, "_valid_lo"}, 128'(bus.key_valid), 128'(0));
      if (t == drop_t) begin
        bus.puf_enable = 1'b0;
        tick();
        chk({tag, "_drop_err"}, 128'(error), 128'(1));
        chk({tag, "_drop_busy"}, 128'(busy), 128'(0));
        chk({tag, "_drop_valid"}, 128'(bus.key_valid), 128'(0));
        tick();
        chk({tag, "_drop_valid2"}, 128'(bus.key_valid), 128'(0));
        bus.puf_enable = 1'b1;
        return;
      end
      tick();
    end
    chk({tag, "_valid"}, 128'(bus.key_valid), 128'(1));
    chk({tag, "_busy_hold"}, 128'(busy), 128'(0));
    chk({tag, "_key"}, bus.key_out, ek);
    chk({tag, "_unstable"}, 128'(unstable_bits), 128'(eu));
    chk({tag, "_err"}, 128'(error), 128'(0));
    for (int h = 0; h < hold; h++) begin
      start = h == 2;
      bus.puf_key = rnd128();
      tick();
      chk({tag, "_bp_valid"}, 128'(bus.key_valid), 128'(1));
      chk({tag, "_bp_key"}, bus.key_out, ek);
      chk({tag, "_bp_unstable"}, 128'(unstable_bits), 128'(eu));
    end
    start = 1'b0;
    bus.key_ready = 1'b1;
    tick();
    bus.key_ready = 1'b0;
    chk({tag, "_ack_valid"}, 128'(bus.key_valid), 128'(0));
    chk({tag, "_ack_busy"}, 128'(busy), 128'(0));
    chk({tag, "_keep_key"}, bus.key_out, ek);
  endtask
  initial begin
    logic [127:0] base;
    bus.puf_key = '0;
    bus.puf_enable = 1'b0;
    bus.key_ready = 1'b0;
    tick();
    tick();
    chk("rst_key", bus.key_out, 128'(0));
    chk("rst_valid", 128'(bus.key_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(error), 128'(0));
    chk("rst_unstable", 128'(unstable_bits), 128'(0));
    reset = 1'b1;
    tick();
    chk("rst_idle", 128'(busy), 128'(0));
    for (int s = 0; s < N; s++) smp[s] = 128'h0123456789ABCDEF_FEDCBA9876543210;
    run("stable", 10, -1);
    chk("stable_val", bus.key_out, 128'h0123456789ABCDEF_FEDCBA9876543210);
    start = 1'b1;
    bus.puf_enable = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("mid_busy_pre", 128'(busy), 128'(1));
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_key", bus.key_out, 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_valid", 128'(bus.key_valid), 128'(0));
    chk("mid_rst_unstable", 128'(unstable_bits), 128'(0));
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_idle", 128'(busy), 128'(0));
    base = rnd128();
    for (int s = 0; s < N; s++) begin
      smp[s] = base;
      smp[s][0] = s % 2 == 0;
      smp[s][5] = s % 2 == 1;
    end
    run("noisy", 0, -1);
    chk("noisy_b0", 128'(bus.key_out[0]), 128'(1));
    chk("noisy_b5", 128'(bus.key_out[5]), 128'(0));
    chk("noisy_cnt", 128'(unstable_bits), 128'(2));
    for (int r = 0; r < 3; r++) begin
      base = rnd128();
      for (int s = 0; s < N; s++) smp[s] = base ^ (rnd128() & rnd128() & rnd128());
      run("rand", int'($urandom_range(0, 4)), -1);
    end
    for (int s = 0; s < N; s++) smp[s] = rnd128();
    run("wild", 1, -1);
    bus.puf_enable = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < TO; w++) begin
      chk("to_busy", 128'(busy), 128'(1));
      chk("to_err_lo", 128'(error), 128'(0));
      tick();
    end
    chk("to_err", 128'(error), 128'(1));
    chk("to_busy_end", 128'(busy), 128'(0));
    chk("to_valid", 128'(bus.key_valid), 128'(0));
    repeat (3) tick();
    chk("to_sticky", 128'(error), 128'(1));
    for (int s = 0; s < N; s++) smp[s] = rnd128();
    run("drop", 0, G + 2);
    chk("drop_sticky", 128'(error), 128'(1));
    run("recover", 2, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
